// File: rtl/prince_ctrl_pkg.sv
// Shared definitions for the PRINCE encryption/decryption sequencers:
// state encoding, round-constant index landmarks and the alpha reflection constant.
package prince_ctrl_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FWD   = 3'd2,
    ST_MID   = 3'd3,
    ST_BWD   = 3'd4,
    ST_FINAL = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  localparam logic [3:0] RC_FIRST = 4'd11;
  localparam logic [3:0] RC_MID   = 4'd6;
  localparam logic [3:0] RC_LAST  = 4'd0;

  // Reflection constant: k1 ^ ALPHA turns the encryption key schedule into decryption.
  localparam logic [63:0] ALPHA = 64'hc0ac_29b7_c97c_50dd;

endpackage

// File: rtl/prince_stage_counter.sv
// Per-round cycle counter: counts 0..term while enabled, pulses wrap on the terminal
// cycle and returns to 0; clr forces 0 outside the round phases.
module prince_stage_counter
  import prince_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q;

  assign wrap = en && (cnt_q == term);
  assign cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/prince_dec_controller.sv
// Decryption-direction sequencer for the masked round-based PRINCE datapath:
// walks RC index 11..0 through load, forward, middle, backward and final phases.
module prince_dec_controller
  import prince_ctrl_pkg::*;
#(
  parameter int SBOX_STAGES = 2,
  parameter int HALF_ROUNDS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       ack,
  output logic       busy,
  output logic       done,
  output logic       load_sel,
  output logic       fwd_sel,
  output logic       mid_sel,
  output logic       bwd_sel,
  output logic       final_sel,
  output logic [3:0] rc_idx,
  output logic [3:0] stage_cnt,
  output logic       rnd_en
);

  localparam logic [3:0] ROUND_TC   = 4'(SBOX_STAGES - 1);
  localparam logic [3:0] MID_TC     = 4'(2 * SBOX_STAGES - 1);
  // Last backward round constant; the final whitening then uses RC_LAST.
  localparam logic [3:0] RC_BWD_END = 4'(int'(RC_MID) - HALF_ROUNDS);

  state_e     state_q, state_d;
  logic [3:0] rc_q, rc_d;
  logic       rnd_q, rnd_d;
  logic       cnt_en, cnt_wrap;
  logic [3:0] cnt_term;

  assign cnt_en   = (state_q == ST_FWD) || (state_q == ST_MID) || (state_q == ST_BWD);
  assign cnt_term = (state_q == ST_MID) ? MID_TC : ROUND_TC;

  prince_stage_counter u_stage_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (!cnt_en),
    .en    (cnt_en),
    .term  (cnt_term),
    .cnt   (stage_cnt),
    .wrap  (cnt_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rc_q    <= RC_FIRST;
      rnd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      rnd_q   <= rnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          rc_d    = RC_FIRST;
        end
      end
      ST_LOAD: begin
        state_d = ST_FWD;
        rc_d    = RC_FIRST - 4'd1;
      end
      ST_FWD: begin
        if (cnt_wrap) begin
          if (rc_q == RC_MID) state_d = ST_MID;
          else                rc_d    = rc_q - 4'd1;
        end
      end
      ST_MID: begin
        if (cnt_wrap) begin
          state_d = ST_BWD;
          rc_d    = RC_MID - 4'd1;
        end
      end
      ST_BWD: begin
        if (cnt_wrap) begin
          if (rc_q == RC_BWD_END) begin
            state_d = ST_FINAL;
            rc_d    = RC_LAST;
          end else begin
            rc_d = rc_q - 4'd1;
          end
        end
      end
      ST_FINAL: state_d = ST_DONE;
      ST_DONE: begin
        if (ack) begin
          state_d = ST_IDLE;
          rc_d    = RC_FIRST;
        end
      end
      default: begin
        state_d = ST_IDLE;
        rc_d    = RC_FIRST;
      end
    endcase
    // Masks are refreshed on every S-box-bearing cycle.
    rnd_d = (state_d == ST_FWD) || (state_d == ST_MID) || (state_d == ST_BWD);
  end

  assign busy      = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done      = (state_q == ST_DONE);
  assign load_sel  = (state_q == ST_LOAD);
  assign fwd_sel   = (state_q == ST_FWD);
  assign mid_sel   = (state_q == ST_MID);
  assign bwd_sel   = (state_q == ST_BWD);
  assign final_sel = (state_q == ST_FINAL);
  assign rc_idx    = rc_q;
  assign rnd_en    = rnd_q;

endmodule

// File: tb/tb_prince_dec_controller.sv
// Directed bench for prince_dec_controller: SBOX_STAGES=2 and SBOX_STAGES=3 instances.
module tb_prince_dec_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, ack = 1'b0, start3 = 1'b0, ack3 = 1'b0;

  logic busy, done, load_sel, fwd_sel, mid_sel, bwd_sel, final_sel, rnd_en;
  logic [3:0] rc_idx, stage_cnt;
  logic busy3, done3, load_sel3, fwd_sel3, mid_sel3, bwd_sel3, final_sel3, rnd_en3;
  logic [3:0] rc_idx3, stage_cnt3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prince_dec_controller #(.SBOX_STAGES(2), .HALF_ROUNDS(5)) dut (
    .clk(clk), .reset(reset), .start(start), .ack(ack),
    .busy(busy), .done(done), .load_sel(load_sel), .fwd_sel(fwd_sel),
    .mid_sel(mid_sel), .bwd_sel(bwd_sel), .final_sel(final_sel),
    .rc_idx(rc_idx), .stage_cnt(stage_cnt), .rnd_en(rnd_en)
  );

  prince_dec_controller #(.SBOX_STAGES(3), .HALF_ROUNDS(5)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .ack(ack3),
    .busy(busy3), .done(done3), .load_sel(load_sel3), .fwd_sel(fwd_sel3),
    .mid_sel(mid_sel3), .bwd_sel(bwd_sel3), .final_sel(final_sel3),
    .rc_idx(rc_idx3), .stage_cnt(stage_cnt3), .rnd_en(rnd_en3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Packed view {busy, done, final, bwd, mid, fwd, load, rc[3:0], stage[3:0], rnd}
  function automatic logic [15:0] obs(input int s);
    if (s == 3)
      return {busy3, done3, final_sel3, bwd_sel3, mid_sel3, fwd_sel3, load_sel3,
              rc_idx3, stage_cnt3, rnd_en3};
    return {busy, done, final_sel, bwd_sel, mid_sel, fwd_sel, load_sel,
            rc_idx, stage_cnt, rnd_en};
  endfunction

  localparam logic [15:0] IDLE_VEC = {1'b0, 1'b0, 5'b00000, 4'd11, 4'd0, 1'b0};

  // Expected outputs at cycle c after start is sampled (cycle 1 = LOAD).
  function automatic logic [15:0] expect_at(input int s, input int c);
    int m0 = 2 + 5 * s;
    int b0 = m0 + 2 * s;
    int f0 = b0 + 5 * s;
    logic bz = 1'b1, dn = 1'b0, rnd = 1'b0;
    logic [4:0] sel = 5'b00000;
    logic [3:0] rc = 4'd0, st = 4'd0;
    if (c == 1) begin
      sel = 5'b00001; rc = 4'd11;
    end else if (c < m0) begin
      sel = 5'b00010; rc = 4'(10 - (c - 2) / s); st = 4'((c - 2) % s); rnd = 1'b1;
    end else if (c < b0) begin
      sel = 5'b00100; rc = 4'd6; st = 4'(c - m0); rnd = 1'b1;
    end else if (c < f0) begin
      sel = 5'b01000; rc = 4'(5 - (c - b0) / s); st = 4'((c - b0) % s); rnd = 1'b1;
    end else if (c == f0) begin
      sel = 5'b10000;
    end else begin
      bz = 1'b0; dn = 1'b1;
    end
    return {bz, dn, sel, rc, st, rnd};
  endfunction

  // One full decryption from start; optional stray start/ack pulses mid-run.
  task automatic run_decrypt(input int s, input bit inject, input string tag);
    int last = 12 * s + 3;
    int rnd_cnt = 0;
    int bad = 0;
    logic [15:0] o, e;
    if (s == 3) start3 = 1'b1; else start = 1'b1;
    tick();
    start = 1'b0; start3 = 1'b0;
    for (int c = 1; c <= last; c++) begin
      o = obs(s);
      e = expect_at(s, c);
      checks++;
      if (o !== e) begin
        failures++; bad++;
        $display("FAIL %s cycle %0d: got busy/done/sel/rc/stage/rnd=%b/%b/%b/%0d/%0d/%b want %b/%b/%b/%0d/%0d/%b",
                 tag, c, o[15], o[14], o[13:9], o[8:5], o[4:1], o[0],
                 e[15], e[14], e[13:9], e[8:5], e[4:1], e[0]);
      end
      if (o[0] === 1'b1) rnd_cnt++;
      if (c < last) begin
        if (inject) begin
          start = (c == 4) || (c == 13);
          ack   = (c == 20) || (c == 21);
        end
        tick();
        start = 1'b0; ack = 1'b0;
      end
    end
    checks++;
    if (rnd_cnt !== 12 * s) begin
      failures++;
      $display("FAIL %s rnd_en count: got %0d want %0d", tag, rnd_cnt, 12 * s);
    end
    $display("txn %s: S=%0d done at cycle %0d, cycle mismatches=%0d, rnd_en=%0d", tag, s, last, bad, rnd_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs(2) !== IDLE_VEC) begin
        failures++;
        $display("FAIL reset_idle cycle %0d: got %h want %h", i, obs(2), IDLE_VEC);
      end
      checks++;
      if (obs(3) !== IDLE_VEC) begin
        failures++;
        $display("FAIL reset_idle_s3 cycle %0d: got %h want %h", i, obs(3), IDLE_VEC);
      end
      tick();
    end
    $display("txn reset: idle checked 5 cycles");
  endtask

  task automatic test_single();
    run_decrypt(2, 1'b0, "single");
  endtask

  task automatic test_done_hold();
    logic [15:0] want_done = {1'b0, 1'b1, 5'b00000, 4'd0, 4'd0, 1'b0};
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs(2) !== want_done) begin
        failures++;
        $display("FAIL done_hold cycle %0d: got %h want %h", i, obs(2), want_done);
      end
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (obs(2) !== IDLE_VEC) begin
      failures++;
      $display("FAIL ack_to_idle: got %h want %h", obs(2), IDLE_VEC);
    end
    $display("txn done_hold: held 10 cycles then acked");
    run_decrypt(2, 1'b0, "second");
  endtask

  task automatic test_ignored_inputs();
    // ack while DONE returns to IDLE; then ack while IDLE must not start anything
    ack = 1'b1; tick(); tick(); ack = 1'b0;
    checks++;
    if (obs(2) !== IDLE_VEC) begin
      failures++;
      $display("FAIL ack_in_idle: got %h want %h", obs(2), IDLE_VEC);
    end
    run_decrypt(2, 1'b1, "stray_pulses");
    start = 1'b1; ack = 1'b1;
    tick();
    start = 1'b0; ack = 1'b0;
    checks++;
    if (obs(2) !== IDLE_VEC) begin
      failures++;
      $display("FAIL start_ack_in_done: got %h want %h", obs(2), IDLE_VEC);
    end
    tick();
    checks++;
    if (obs(2) !== IDLE_VEC) begin
      failures++;
      $display("FAIL start_not_captured: got %h want %h", obs(2), IDLE_VEC);
    end
    $display("txn start_ack_in_done: returned to IDLE without restart");
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 14; c++) tick();
    checks++;
    if (mid_sel !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_precond: mid_sel got %b want 1", mid_sel);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (obs(2) !== IDLE_VEC) begin
      failures++;
      $display("FAIL reset_mid: got %h want %h", obs(2), IDLE_VEC);
    end
    $display("txn reset_mid: aborted in MID");
    run_decrypt(2, 1'b0, "after_reset");
  endtask

  task automatic test_stages3();
    run_decrypt(3, 1'b0, "stages3");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_done_hold();
    test_ignored_inputs();
    test_reset_mid();
    test_stages3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
